mdu_sequencer: RTL
==================

# mdu_sequencer

Multi-cycle multiply/divide unit with its own sequencing FSM, owning the architectural HI/LO registers, sitting in the E stage of the P6 pipeline. It accepts the 4-bit MDU opcode decoded alongside the instruction and operands rs/rt from E. It raises Start/Busy so the hazard unit can stall later MDU instructions in D. It returns HI/LO values for mfhi/mflo.

## Interface
- MULT_CYCLES, 5, Busy length for mult/multu (1..15)
- DIV_CYCLES, 10, Busy length for div/divu (1..15)

- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clears all state
- MDUControl  in  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as 0
- A  in  32  rs operand (E stage)
- B  in  32  rt operand (E stage)
- Start  out  1  combinational: MDUControl in 1..4 and FSM in IDLE
- Busy  out  1  registered: FSM not IDLE
- MDUOut  out  32  combinational: HI if op 5, LO if op 6, else 0
- HI  out  32  architectural HI register
- LO  out  32  architectural LO register

## Operation
- FSM states: IDLE, MUL, DIV. 4-bit down-counter cnt; result latches res_hi/res_lo.
- IDLE, op 1/2 at posedge: compute 64-bit product (signed for 1, unsigned for 2) into res_hi/res_lo; cnt <= MULT_CYCLES-1; -> MUL.
- IDLE, op 3/4 at posedge: quotient -> res_lo, remainder -> res_hi (signed truncating for 3, remainder takes dividend's sign; unsigned for 4); cnt <= DIV_CYCLES-1; -> DIV.
- MUL/DIV: cnt decrements each cycle; on the edge where cnt==0, HI<=res_hi, LO<=res_lo, -> IDLE.
- IDLE, op 7: HI<=A. Op 8: LO<=A. Op 5/6: no state change.
- Any op while Busy is ignored (no state change, Start=0). The hazard unit guarantees none is issued; the bench checks the ignore.
- HI/LO keep old values for the entire busy window. MDUOut during Busy reflects old HI/LO.
- Signed div special case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero: behaviour per Configuration.

## Timing
- Reset values: HI=0, LO=0, Busy=0, state IDLE, cnt=0, res_hi=res_lo=0; Start and MDUOut follow inputs.
- Reset dominates in any state, including mid-operation. The pending result is discarded and HI/LO are cleared on that edge.
- Busy is 0 in the issue cycle, 1 for exactly N cycles after the issue edge (N = MULT_CYCLES or DIV_CYCLES), then 0.
- HI/LO are updated on the same edge that clears Busy. The first cycle with Busy=0 shows the new HI/LO.
- A new op is accepted in the first cycle Busy=0 after completion. There are no dead cycles.
- Hazard contract: stall D while (Start|Busy) and D holds any MDU op 1..8.
- mthi/mtlo write with 1-edge latency. mfhi/mflo are read combinationally in E.

## Configuration
- MDU_DIVZERO_HOLD_EN defined: div/divu with B==0 still run the full DIV_CYCLES Busy window, but HI and LO are left unchanged at completion.
- Undefined: B==0 gives LO=0xFFFFFFFF, HI=A (both signed and unsigned), committed at completion as normal.

## Test plan
- mult A=3, B=0xFFFFFFFE -> Start=1 issue cycle, Busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO=0 throughout the busy window.
- multu A=0xFFFFFFFF, B=2 -> HI=0x00000001, LO=0xFFFFFFFE. Then mfhi -> MDUOut=0x00000001 same cycle.
- div A=0xFFFFFFF9 (-7), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
- During mult Busy, drive mtlo A=0x1234 and divu -> both ignored, Start=0. Completion yields the mult result only. Immediately after, mthi A=0xABCD -> HI=0xABCD next edge.
- div in progress, reset asserted at busy cycle 4 -> next edge Busy=0, HI=LO=0. Old result never appears.
- divu A=5, B=0 with HI=0x11, LO=0x22 preloaded -> with MDU_DIVZERO_HOLD_EN HI=0x11, LO=0x22 after 10 cycles; without it HI=5, LO=0xFFFFFFFF.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer that owns the HI/LO registers for the E stage.
// Optional MDU_DIVZERO_HOLD_EN: a divide by zero leaves HI/LO untouched at completion.
module mdu_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUControl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] MDUOut,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] MUL_LAST = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic        commit_en;

  logic        is_mul, is_div;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, dvd, dvs, q_raw, r_raw, quo, rem;
  logic        div_zero;

  assign is_mul = (MDUControl == OP_MULT) || (MDUControl == OP_MULTU);
  assign is_div = (MDUControl == OP_DIV)  || (MDUControl == OP_DIVU);

  // Sign-extending to 64 bits makes the low 64 bits of the unsigned product the signed product.
  always_comb begin
    if (MDUControl == OP_MULT)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'd0, A} * {32'd0, B};
  end

  // One unsigned divider on magnitudes; signs are restored afterwards (truncating division).
  // 0x80000000 / -1 falls out naturally: magnitude 0x80000000, same signs, no negation.
  assign a_mag    = A[31] ? (~A + 32'd1) : A;
  assign b_mag    = B[31] ? (~B + 32'd1) : B;
  assign div_zero = (B == 32'd0);

  always_comb begin
    dvd = (MDUControl == OP_DIVU) ? A : a_mag;
    dvs = (MDUControl == OP_DIVU) ? B : b_mag;
    if (div_zero) dvs = 32'd1;
  end

  assign q_raw = dvd / dvs;
  assign r_raw = dvd % dvs;

  always_comb begin
    quo = q_raw;
    rem = r_raw;
    if (MDUControl == OP_DIV) begin
      if (A[31] ^ B[31]) quo = ~q_raw + 32'd1;
      if (A[31])         rem = ~r_raw + 32'd1;
    end
  end

  assign Start = (is_mul || is_div) && (state == IDLE);

  always_comb begin
    case (MDUControl)
      OP_MFHI: MDUOut = HI;
      OP_MFLO: MDUOut = LO;
      default: MDUOut = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      res_hi    <= 32'd0;
      res_lo    <= 32'd0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      Busy      <= 1'b0;
      commit_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (is_mul) begin
            res_hi    <= prod[63:32];
            res_lo    <= prod[31:0];
            cnt       <= MUL_LAST;
            commit_en <= 1'b1;
            Busy      <= 1'b1;
            state     <= MUL;
          end else if (is_div) begin
            if (div_zero) begin
              res_hi <= A;
              res_lo <= 32'hFFFF_FFFF;
            end else begin
              res_hi <= rem;
              res_lo <= quo;
            end
`ifdef MDU_DIVZERO_HOLD_EN
            commit_en <= !div_zero;
`else
            commit_en <= 1'b1;
`endif
            cnt   <= DIV_LAST;
            Busy  <= 1'b1;
            state <= DIV;
          end else if (MDUControl == OP_MTHI) begin
            HI <= A;
          end else if (MDUControl == OP_MTLO) begin
            LO <= A;
          end
        end
        MUL, DIV: begin
          // Commit lands on the same edge that drops Busy, so no dead cycle follows.
          if (cnt == 4'd0) begin
            if (commit_en) begin
              HI <= res_hi;
              LO <= res_lo;
            end
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
